// File: rtl/sr_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sr_pkg
//  Brief    : Shared encodings for the shift-register load/shift sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
package sr_pkg;

    localparam logic [1:0] SEL_HOLD = 2'b00;
    localparam logic [1:0] SEL_LOAD = 2'b01;
    localparam logic [1:0] SEL_SHL  = 2'b10;
    localparam logic [1:0] SEL_SHR  = 2'b11;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/sr_shift_cnt.sv
`default_nettype none
// ============================================================================
//  Module   : sr_shift_cnt
//  Brief    : Loadable down-counter for the shift length, clamps to N on load.
//  Revision : 1.0 - initial release
// ============================================================================
module sr_shift_cnt
    import sr_pkg::*;
#(
    parameter int N     = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             clear,
    input  logic             dec,
    output logic             is_one,
    output logic             is_zero
);

    localparam logic [CNT_W-1:0] C_MAX = CNT_W'(N);

    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_clamped;

    assign w_clamped = (load_val > C_MAX) ? C_MAX : load_val;

    // Saturates at zero so a stray decrement can never wrap the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= w_clamped;
        end else if (dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign is_one  = (r_count == CNT_W'(1));
    assign is_zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/sr_load_shift_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : sr_load_shift_ctrl
//  Brief    : Sequences one load then a programmed number of shifts on a
//             parallel-load shift register, exposing the outgoing serial bit.
//  Revision : 1.0 - initial release
// ============================================================================
module sr_load_shift_ctrl
    import sr_pkg::*;
#(
    parameter int N     = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_data,
    input  logic             in_dir,
    input  logic [CNT_W-1:0] in_len,
    input  logic             abort,
    input  logic [N-1:0]     sr_q,
    output logic [1:0]       sel,
    output logic [N-1:0]     par_data,
    output logic             ser_bit,
    output logic             ser_valid,
    output logic             done
);

    state_t     r_state;
    state_t     w_next;
    logic [N-1:0] r_par_data;
    logic       r_dir;
    logic       w_accept;
    logic       w_abort_act;
    logic       w_cnt_one;
    logic       w_cnt_zero;

    assign w_accept    = in_valid && (r_state == ST_IDLE);
    assign w_abort_act = abort && ((r_state == ST_LOAD) || (r_state == ST_SHIFT));

    sr_shift_cnt #(
        .N     (N),
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (w_accept),
        .load_val (in_len),
        .clear    (w_abort_act),
        .dec      (r_state == ST_SHIFT),
        .is_one   (w_cnt_one),
        .is_zero  (w_cnt_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_par_data <= '0;
            r_dir      <= DIR_LEFT;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_par_data <= in_data;
                r_dir      <= in_dir;
            end
        end
    end

    // Abort wins over the count reaching its last shift.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (in_valid) w_next = ST_LOAD;
            ST_LOAD:  w_next = abort ? ST_IDLE : (w_cnt_zero ? ST_DONE : ST_SHIFT);
            ST_SHIFT: w_next = abort ? ST_IDLE : (w_cnt_one ? ST_DONE : ST_SHIFT);
            ST_DONE:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        sel       = SEL_HOLD;
        in_ready  = 1'b0;
        ser_valid = 1'b0;
        done      = 1'b0;
        case (r_state)
            ST_IDLE:  in_ready = 1'b1;
            ST_LOAD:  sel = SEL_LOAD;
            ST_SHIFT: begin
                sel       = (r_dir == DIR_RIGHT) ? SEL_SHR : SEL_SHL;
                ser_valid = 1'b1;
            end
            ST_DONE:  done = 1'b1;
            default:  sel = SEL_HOLD;
        endcase
    end

    // The bit about to leave is the one at the register edge facing the shift.
    assign ser_bit  = (r_state == ST_SHIFT) ?
                      ((r_dir == DIR_RIGHT) ? sr_q[0] : sr_q[N-1]) : 1'b0;
    assign par_data = r_par_data;

    logic unused_sr_bits;
    assign unused_sr_bits = ^sr_q[N-2:1];

endmodule
`default_nettype wire

// File: tb/tb_sr_load_shift_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sr_load_shift_ctrl
//  Brief    : Self-checking bench with a downstream register and trace model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sr_load_shift_ctrl;

    localparam int N     = 8;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     in_data;
    logic             in_dir;
    logic [CNT_W-1:0] in_len;
    logic             abort;
    logic [N-1:0]     sr_q;
    logic [1:0]       sel;
    logic [N-1:0]     par_data;
    logic             ser_bit;
    logic             ser_valid;
    logic             done;

    int errors = 0;
    int checks = 0;

    sr_load_shift_ctrl #(.N(N), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_dir    (in_dir),
        .in_len    (in_len),
        .abort     (abort),
        .sr_q      (sr_q),
        .sel       (sel),
        .par_data  (par_data),
        .ser_bit   (ser_bit),
        .ser_valid (ser_valid),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Downstream parallel-load shift register, zero fill on shifts.
    logic [N-1:0] reg_q;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) reg_q <= '0;
        else begin
            case (sel)
                2'b01:   reg_q <= par_data;
                2'b10:   reg_q <= {reg_q[N-2:0], 1'b0};
                2'b11:   reg_q <= {1'b0, reg_q[N-1:1]};
                default: reg_q <= reg_q;
            endcase
        end
    end
    assign sr_q = reg_q;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Entered just after a negedge with the DUT idle; returns after a negedge, idle.
    task automatic run_req(input logic [N-1:0] d, input logic dr, input logic [CNT_W-1:0] len,
                           input int abort_at, input logic idle_abort, input logic done_abort);
        int L;
        int last;
        int i;
        logic [1:0]   e_sel;
        logic         e_sv, e_bit, e_done, e_rdy;
        logic [N-1:0] e_reg;
        L    = (int'(len) > N) ? N : int'(len);
        last = (abort_at > 0) ? abort_at + 1 : L + 2;
        chk("pre_ready", 32'(in_ready), 32'd1);
        chk("pre_sel", 32'(sel), 32'd0);
        in_valid = 1'b1; in_data = d; in_dir = dr; in_len = len; abort = idle_abort;
        @(posedge clk); #1;
        in_valid = 1'b0; abort = 1'b0;
        in_data = N'($urandom); in_dir = 1'($urandom); in_len = CNT_W'($urandom);
        for (int c = 1; c <= last + 1; c++) begin
            @(negedge clk);
            abort = 1'b0;
            e_sel = 2'b00; e_sv = 1'b0; e_bit = 1'b0; e_done = 1'b0; e_rdy = 1'b0;
            if (c == 1) begin
                e_sel = 2'b01;
            end else if (c <= 1 + L && (abort_at == 0 || c <= 1 + abort_at)) begin
                i     = c - 2;
                e_sel = dr ? 2'b11 : 2'b10;
                e_sv  = 1'b1;
                e_bit = dr ? d[i] : d[N-1-i];
            end else if (abort_at == 0 && c == L + 2) begin
                e_done = 1'b1;
            end else begin
                e_rdy = 1'b1;
            end
            chk("sel", 32'(sel), 32'(e_sel));
            chk("ser_valid", 32'(ser_valid), 32'(e_sv));
            chk("ser_bit", 32'(ser_bit), 32'(e_bit));
            chk("done", 32'(done), 32'(e_done));
            chk("in_ready", 32'(in_ready), 32'(e_rdy));
            chk("par_data", 32'(par_data), 32'(d));
            if (c == last + 1 && abort_at == 0) begin
                e_reg = dr ? (d >> L) : (d << L);
                chk("reg_final", 32'(reg_q), 32'(e_reg));
            end
            if (abort_at > 0 && c == 1 + abort_at) abort = 1'b1;
            if (abort_at == 0 && c == L + 2) abort = done_abort;
        end
        abort = 1'b0;
    endtask

    initial begin
        int len_r, l_c, ab;
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_dir = 1'b0; in_len = '0; abort = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_sel", 32'(sel), 32'd0);
        chk("rst_par", 32'(par_data), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd1);
        chk("rst_sv", 32'(ser_valid), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_bit", 32'(ser_bit), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_req(8'hA5, 1'b0, 4'd8, 0, 1'b0, 1'b0);
        run_req(8'h01, 1'b1, 4'd3, 0, 1'b0, 1'b0);
        run_req(8'h3C, 1'b0, 4'd0, 0, 1'b0, 1'b0);
        run_req(8'hC3, 1'b1, 4'd15, 0, 1'b0, 1'b0);
        run_req(8'h96, 1'b0, 4'd8, 4, 1'b0, 1'b0);
        run_req(8'h5A, 1'b1, 4'd6, 0, 1'b1, 1'b1);

        // Asynchronous reset in the middle of shifting.
        in_valid = 1'b1; in_data = 8'hFF; in_dir = 1'b0; in_len = 4'd8;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_rst_sv", 32'(ser_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_sel", 32'(sel), 32'd0);
        chk("arst_sv", 32'(ser_valid), 32'd0);
        chk("arst_par", 32'(par_data), 32'd0);
        chk("arst_bit", 32'(ser_bit), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_ready", 32'(in_ready), 32'd1);
            chk("post_rst_done", 32'(done), 32'd0);
            chk("post_rst_sel", 32'(sel), 32'd0);
        end

        for (int n = 0; n < 30; n++) begin
            len_r = $urandom_range(0, 15);
            l_c   = (len_r > N) ? N : len_r;
            ab    = (l_c > 0 && $urandom_range(0, 3) == 0) ? $urandom_range(1, l_c) : 0;
            run_req(N'($urandom), 1'($urandom), CNT_W'(len_r), ab, 1'($urandom), 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
